// File: rtl/reduce_gate_accum.sv
// reduce_gate_accum: frame-based OR/AND/XOR reduction with a saturating ones count.
// Each accepted beat is inverted by BubblesMask, reduced to one bit, and folded into
// a per-frame accumulator. The frame result is held until the consumer accepts it.
module reduce_gate_accum #(
    parameter int                    NrOfInputs  = 29,
    parameter logic [NrOfInputs-1:0] BubblesMask = '0,
    parameter int                    CountWidth  = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NrOfInputs-1:0] Data_In,
    input  logic                  Data_Valid,
    input  logic                  Data_Last,
    output logic                  Data_Ready,
    input  logic [1:0]            Mode,
    output logic                  Result,
    output logic [CountWidth-1:0] Count,
    output logic                  Overflow,
    output logic                  Result_Valid,
    input  logic                  Result_Ready
);

    // Popcount of up to 64 bits fits in 7 bits; the sum width covers the largest
    // count plus one full beat without wrapping.
    localparam int PopWidth = 7;
    localparam int SumWidth = CountWidth + 8;
    localparam logic [SumWidth-1:0] CntMax = {{(SumWidth - CountWidth){1'b0}}, {CountWidth{1'b1}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic                    first;
    logic [1:0]              mode_q;
    logic                    acc;
    logic [CountWidth-1:0]   cnt;
    logic                    ovf;

    logic [NrOfInputs-1:0]   real_bits;
    logic [1:0]              mode_eff;
    logic                    beat_red;
    logic                    acc_next;
    logic [PopWidth-1:0]     pop;
    logic [SumWidth-1:0]     sum;
    logic [CountWidth-1:0]   cnt_next;
    logic                    ovf_next;
    logic                    accept;

    function automatic logic [PopWidth-1:0] popcount(input logic [NrOfInputs-1:0] v);
        logic [PopWidth-1:0] n;
        n = '0;
        for (int i = 0; i < NrOfInputs; i++) begin
            n = n + PopWidth'(v[i]);
        end
        return n;
    endfunction

    // Beat datapath: inversion, beat reduction, fold into accumulator, saturating count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        real_bits = Data_In ^ BubblesMask;
        mode_eff  = first ? Mode : mode_q;
        accept    = Data_Valid && (state == ACCUM);
        pop       = popcount(real_bits);

        case (mode_eff)
            2'b01:   beat_red = &real_bits;
            2'b10:   beat_red = ^real_bits;
            default: beat_red = |real_bits;
        endcase

        if (first) begin
            acc_next = beat_red;
        end else begin
            case (mode_eff)
                2'b01:   acc_next = acc & beat_red;
                2'b10:   acc_next = acc ^ beat_red;
                default: acc_next = acc | beat_red;
            endcase
        end

        sum = (first ? '0 : SumWidth'(cnt)) + SumWidth'(pop);
        if (sum > CntMax) begin
            cnt_next = '1;
            ovf_next = 1'b1;
        end else begin
            cnt_next = sum[CountWidth-1:0];
            ovf_next = first ? 1'b0 : ovf;
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (Reset) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next   = state;
        Data_Ready   = 1'b0;
        Result_Valid = 1'b0;
        case (state)
            ACCUM: begin
                Data_Ready = 1'b1;
                if (accept && Data_Last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                Result_Valid = 1'b1;
                if (Result_Ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Frame accumulator and presented result; results only change when a frame closes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            first    <= 1'b1;
            mode_q   <= '0;
            acc      <= 1'b0;
            cnt      <= '0;
            ovf      <= 1'b0;
            Result   <= 1'b0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (accept) begin
            if (first) begin
                mode_q <= Mode;
            end
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            // Closing a frame re-arms the first-beat flag for the frame after the handshake.
            first <= Data_Last;
            if (Data_Last) begin
                Result   <= acc_next;
                Count    <= cnt_next;
                Overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_reduce_gate_accum.sv
// Directed bench for reduce_gate_accum with a result scoreboard.
module tb_reduce_gate_accum;

    typedef struct packed {
        logic       result;
        logic [2:0] count;
        logic       overflow;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic [1:0] mode;
    logic       result;
    logic [2:0] count;
    logic       overflow;
    logic       result_valid;
    logic       result_ready;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    reduce_gate_accum #(
        .NrOfInputs (4),
        .BubblesMask(4'b0001),
        .CountWidth (3)
    ) dut (
        .Clock       (clk),
        .Reset       (reset),
        .Data_In     (data_in),
        .Data_Valid  (data_valid),
        .Data_Last   (data_last),
        .Data_Ready  (data_ready),
        .Mode        (mode),
        .Result      (result),
        .Count       (count),
        .Overflow    (overflow),
        .Result_Valid(result_valid),
        .Result_Ready(result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat for one cycle; a closing beat pushes its expected frame result.
    task automatic send(input logic [3:0] d, input logic [1:0] m, input logic last,
                        input bit push, input exp_t e);
        check("ready_before_beat", 32'(data_ready), 32'd1);
        data_in    = d;
        mode       = m;
        data_valid = 1'b1;
        data_last  = last;
        tick();
        data_valid = 1'b0;
        data_last  = 1'b0;
        if (last && push) sb.push_back(e);
    endtask

    // Compare the presented result with the scoreboard, then complete the handshake.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_result"}, 32'(result), 32'(e.result));
        check({tag, "_count"}, 32'(count), 32'(e.count));
        check({tag, "_overflow"}, 32'(overflow), 32'(e.overflow));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        data_valid   = 1'b0;
        check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(data_ready), 32'd1);
        check({tag, "_count_kept"}, 32'(count), 32'(e.count));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        data_in      = '0;
        data_valid   = 1'b0;
        data_last    = 1'b0;
        mode         = 2'b00;
        result_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // OR one-beat frame held under backpressure with Data_Valid asserted.
        send(4'b0001, 2'b00, 1'b1, 1'b1, '{result: 1'b0, count: 3'd0, overflow: 1'b0});
        data_in      = 4'b1111;
        data_valid   = 1'b1;
        result_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(result_valid), 32'd1);
            check("bp_result", 32'(result), 32'd0);
            check("bp_count", 32'(count), 32'd0);
            check("bp_ready", 32'(data_ready), 32'd0);
            tick();
        end
        collect("or_one_beat");

        // AND two beats, count saturates.
        send(4'b1110, 2'b01, 1'b0, 1'b0, '0);
        send(4'b1110, 2'b01, 1'b1, 1'b1, '{result: 1'b1, count: 3'd7, overflow: 1'b1});
        collect("and_sat");

        // XOR frame; the second beat's Mode is ignored.
        send(4'b0000, 2'b10, 1'b0, 1'b0, '0);
        send(4'b0110, 2'b00, 1'b1, 1'b1, '{result: 1'b0, count: 3'd4, overflow: 1'b0});
        collect("xor_lock");

        // Reset mid-frame discards the partial frame and clears presented outputs.
        send(4'b1111, 2'b00, 1'b0, 1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", 32'(data_ready), 32'd1);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        send(4'b0001, 2'b00, 1'b1, 1'b1, '{result: 1'b0, count: 3'd0, overflow: 1'b0});
        collect("after_reset");

        // Mode 11 behaves as OR.
        send(4'b0000, 2'b11, 1'b1, 1'b1, '{result: 1'b1, count: 3'd1, overflow: 1'b0});
        collect("mode11");

        // Long OR frame keeps saturating: 4+4+4+1 ones.
        send(4'b1110, 2'b00, 1'b0, 1'b0, '0);
        send(4'b1110, 2'b00, 1'b0, 1'b0, '0);
        send(4'b1110, 2'b00, 1'b0, 1'b0, '0);
        send(4'b0000, 2'b01, 1'b1, 1'b1, '{result: 1'b1, count: 3'd7, overflow: 1'b1});
        collect("long_or");

        // A held result is dropped by reset without a handshake.
        send(4'b0000, 2'b00, 1'b1, 1'b0, '0);
        check("held_valid", 32'(result_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("drop_valid", 32'(result_valid), 32'd0);
        check("drop_ready", 32'(data_ready), 32'd1);
        check("drop_result", 32'(result), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reduce_gate_accum.md
REDUCE_GATE_ACCUM -- requirements
Module: reduce_gate_accum

Interface
REQ-001 SHALL have parameter NrOfInputs, default 29, giving the input vector width (legal 1..64).
REQ-002 SHALL have parameter BubblesMask, default 0, NrOfInputs bits; bit i set inverts Data_In[i] before reduction.
REQ-003 SHALL have parameter CountWidth, default 10, giving the ones-count width (legal 2..16).
REQ-004 SHALL use one clock and a synchronous, active-high reset. Ports: Clock in 1, rising-edge clock; Reset in 1, synchronous active-high reset.
REQ-005 SHALL have port Data_In in NrOfInputs, the beat payload.
REQ-006 SHALL have port Data_Valid in 1, which qualifies Data_In.
REQ-007 SHALL have port Data_Last in 1, which marks the final beat of a frame.
REQ-008 SHALL have port Data_Ready out 1, high when a beat can be accepted.
REQ-009 SHALL have port Mode in 2, the reduction operator: 00 OR, 01 AND, 10 XOR, 11 OR.
REQ-010 SHALL have port Result out 1, the frame reduction result.
REQ-011 SHALL have port Count out CountWidth, the saturating count of ones in the frame after inversion.
REQ-012 SHALL have port Overflow out 1, high when Count saturated in the frame.
REQ-013 SHALL have port Result_Valid out 1, which qualifies Result, Count and Overflow.
REQ-014 SHALL have port Result_Ready in 1, the consumer acceptance signal.

Function
REQ-015 SHALL compute real = Data_In XOR BubblesMask for every beat.
REQ-016 SHALL accept a beat only in a cycle where Data_Valid and Data_Ready are both 1. Beats in any other cycle have no effect.
REQ-017 SHALL implement FSM states ACCUM and HOLD. Data_Ready = 1 in ACCUM and 0 in HOLD; Result_Valid = 1 exactly in HOLD.
REQ-018 SHALL sample Mode on the first accepted beat of a frame and use it for the whole frame. Mode changes mid-frame are ignored.
REQ-019 On the first beat of a frame, SHALL load acc = beat reduction of real under the sampled Mode, and load cnt = popcount(real).
REQ-020 On later beats, SHALL update acc = acc OP beatreduction (OP is OR, AND or XOR per Mode) and cnt = cnt + popcount(real).
REQ-021 SHALL saturate cnt at 2^CountWidth-1. If the unsaturated sum exceeds this, the sticky per-frame Overflow flag is set.
REQ-022 When a beat with Data_Last=1 is accepted, SHALL transition ACCUM->HOLD. Result, Count and Overflow, including that beat, become valid with Result_Valid=1 on the next cycle (1-cycle latency).
REQ-023 A single beat with Data_Last=1 SHALL be a complete one-beat frame.
REQ-024 In HOLD, SHALL keep Result, Count and Overflow stable until Result_Valid and Result_Ready are both 1.
REQ-025 On that handshake, SHALL return to ACCUM with the first-beat flag set. Data_Ready rises on the next cycle, giving one bubble cycle between frames.
REQ-026 SHALL keep Result, Count and Overflow at their last presented values while in ACCUM. They update only on entering HOLD.
REQ-027 SHALL give a frame with no Data_Last unbounded length. Count saturates per REQ-021 and acc keeps accumulating.

Reset
REQ-028 When Reset=1 at a clock edge, SHALL go to ACCUM with the first-beat flag set. Outputs after reset: Data_Ready=1, Result=0, Count=0, Overflow=0, Result_Valid=0; acc, cnt and the sampled Mode are cleared.
REQ-029 Reset SHALL take priority over any simultaneous beat or result handshake. A partial frame is discarded, and a held result is dropped without a handshake.

Verification
(Bench parameters: NrOfInputs=4, BubblesMask=4'b0001, CountWidth=3.)
REQ-030 OR, one beat: Mode=00, Data_In=0001, Last=1 -> next cycle Result_Valid=1, Result=0, Count=0, Overflow=0.
REQ-031 AND, two beats: Mode=01, Data_In=1110 then 1110 with Last -> Result=1, Count=7 (saturated from 8), Overflow=1.
REQ-032 XOR plus mode lock: Mode=10, Data_In=0000, then Mode=00 with Data_In=0110 and Last -> Result=0, Count=4, Overflow=0.
REQ-033 Backpressure: after REQ-030, hold Result_Ready=0 for 5 cycles and drive Data_Valid=1 -> Result_Valid, Result and Count stable and Data_Ready=0. Then Result_Ready=1 for 1 cycle -> Result_Valid=0 and Data_Ready=1 on the following cycle.
REQ-034 Reset mid-frame: Mode=00, beat 1111 without Last, then Reset for 1 cycle, then Mode=00 with beat 0001 and Last -> Result=0, Count=0.
REQ-035 Mode 11, one beat: Data_In=0000, Last=1 -> Result=1, Count=1 (OR behaviour).
